// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults, word type and width helper for the async_fifo read-side blocks
package fifo_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;

    typedef logic [DEF_DATA_WIDTH-1:0] word_t;

    // ceil(log2(n)), never below 1 so it can size pointers and counters directly
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/skid_ring.sv
// skid_ring: DEPTH-entry register ring buffer with push, pop, head view, count and clear
// Ports: clk, rst_n (async active-low), i_clr (sync clear of pointers/count), i_push/i_data (write tail),
//        i_pop (advance head), o_head (entry at head), o_count (entries held)
module skid_ring
    import fifo_pkg::*;
#(
    parameter int DW    = DEF_DATA_WIDTH,
    parameter int DEPTH = 2,
    localparam int PW   = clog2(DEPTH),
    localparam int CW   = clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_head,
    output logic [CW-1:0] o_count
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_cnt;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (i_clr) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wp] <= i_data;
                r_wp        <= inc(r_wp);
            end
            if (i_pop) r_rp <= inc(r_rp);
            r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rp];
    assign o_count = r_cnt;
endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter: converts async_fifo pop interface (1-cycle registered read) into a valid/ready stream
// Ports: rd_clk, rd_rst_n (async active-low); fifo_empty/fifo_rd_en/fifo_rd_data to async_fifo;
//        flush (sync discard of buffered and in-flight words); m_valid/m_ready/m_data downstream stream;
//        occupancy (words in skid buffer); word_cnt (wrapping count of delivered words)
module fifo_rd_stream_adapter
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SKID_DEPTH = 2,
    parameter int CNT_WIDTH  = 16,
    localparam int OW        = clog2(SKID_DEPTH + 1)
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [OW-1:0]         occupancy,
    output logic [CNT_WIDTH-1:0]  word_cnt
);
    logic                 r_inflight;
    logic                 r_drop;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 w_acc;
    logic                 w_push;

    // an accept during flush is ignored
    assign w_acc = m_valid && m_ready && !flush;

    // credit check counts the word already in flight so the ring can never overflow;
    // reset gating keeps the FIFO from being popped while this block is held in reset
    assign fifo_rd_en = rd_rst_n && !fifo_empty && !flush &&
                        (int'(occupancy) + int'(r_inflight) - int'(w_acc) < SKID_DEPTH);

    // the word arriving in a flush cycle was already popped from async_fifo; it is discarded
    assign w_push  = r_inflight && !r_drop && !flush;
    assign m_valid = (occupancy != '0);

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_inflight <= 1'b0;
            r_drop     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_inflight <= fifo_rd_en;
            r_drop     <= flush && r_inflight;
            if (w_acc) r_cnt <= r_cnt + 1'b1;
        end
    end

    skid_ring #(
        .DW    (DATA_WIDTH),
        .DEPTH (SKID_DEPTH)
    ) u_ring (
        .clk     (rd_clk),
        .rst_n   (rd_rst_n),
        .i_clr   (flush),
        .i_push  (w_push),
        .i_pop   (w_acc),
        .i_data  (fifo_rd_data),
        .o_head  (m_data),
        .o_count (occupancy)
    );

    assign word_cnt = r_cnt;
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// tb_fifo_rd_stream_adapter: scoreboard bench with a queue-based async_fifo model and stream reference
module tb_fifo_rd_stream_adapter;
    localparam int DW = 8;
    localparam int D  = 2;
    localparam int CW = 16;

    logic          rd_clk = 1'b0;
    logic          rd_rst_n = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          flush = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] word_cnt;

    int total = 0;
    int bad = 0;
    int pops = 0;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] expq[$];

    fifo_rd_stream_adapter #(.DATA_WIDTH(DW), .SKID_DEPTH(D), .CNT_WIDTH(CW)) dut (
        .rd_clk       (rd_clk),
        .rd_rst_n     (rd_rst_n),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .flush        (flush),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .occupancy    (occupancy),
        .word_cnt     (word_cnt)
    );

    always #10 rd_clk = ~rd_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // async_fifo model: registered read, data appears 1 cycle after an accepted pop
    initial begin
        logic [DW-1:0] w;
        bit pend;
        w = '0;
        forever begin
            @(negedge rd_clk);
            #1 fifo_empty = (fq.size() == 0);
            #1 pend = 0;
            if (rd_rst_n && fifo_rd_en) begin
                if (fq.size() == 0) chk("pop_while_empty", 1, 0);
                else begin
                    w = fq.pop_front();
                    pops++;
                    expq.push_back(w);
                    pend = 1;
                end
            end
            if (rd_rst_n && flush) expq.delete();
            @(posedge rd_clk);
            #1 fifo_rd_data = pend ? w : DW'($urandom);
        end
    end

    // monitor: reference stream behaviour derived from occupancy/credit rules and the scoreboard
    initial begin
        int occ, infl, acc, exp_pop;
        logic [CW-1:0] cnt;
        bit hold;
        logic [DW-1:0] hd;
        occ = 0; infl = 0; cnt = '0; hold = 0; hd = '0;
        forever begin
            @(negedge rd_clk);
            #3;
            if (!rd_rst_n) begin
                occ = 0; infl = 0; cnt = '0; hold = 0;
                expq.delete();
            end else begin
                acc = (m_valid && m_ready && !flush) ? 1 : 0;
                exp_pop = (!fifo_empty && !flush && (occ + infl - acc < D)) ? 1 : 0;
                chk("rd_en", 32'(fifo_rd_en), 32'(exp_pop));
                chk("occupancy", 32'(occupancy), 32'(occ));
                chk("m_valid", 32'(m_valid), 32'(occ != 0));
                chk("word_cnt", 32'(word_cnt), 32'(cnt));
                if (hold) chk("hold_data", 32'(m_data), 32'(hd));
                if (acc == 1) begin
                    if (expq.size() == 0) chk("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
                    else chk("data", 32'(m_data), 32'(expq.pop_front()));
                end
                hold = m_valid && !m_ready && !flush;
                hd = m_data;
                occ = flush ? 0 : occ + infl - acc;
                infl = fifo_rd_en ? 1 : 0;
                cnt = cnt + CW'(acc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int p0, n;
        #50;
        chk("rst_rd_en", 32'(fifo_rd_en), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_occupancy", 32'(occupancy), 0);
        chk("rst_word_cnt", 32'(word_cnt), 0);
        chk("rst_m_data", 32'(m_data), 0);
        @(negedge rd_clk);
        rd_rst_n = 1'b1;

        // streaming
        @(negedge rd_clk);
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) fq.push_back(DW'(i));
        repeat (25) @(negedge rd_clk);
        chk("stream_cnt", 32'(word_cnt), 16);

        // back-pressure
        m_ready = 1'b0;
        p0 = pops;
        for (int i = 0; i < 16; i++) fq.push_back(DW'(i));
        repeat (10) @(negedge rd_clk);
        chk("bp_pops", 32'(pops - p0), 2);
        chk("bp_occupancy", 32'(occupancy), 2);
        chk("bp_head", 32'(m_data), 0);
        m_ready = 1'b1;
        repeat (30) @(negedge rd_clk);
        chk("bp_cnt", 32'(word_cnt), 32);

        // empty boundary
        for (int i = 0; i < 5; i++) fq.push_back(DW'(8'h50 + i));
        repeat (20) begin
            @(negedge rd_clk);
            m_ready = $urandom_range(0, 1) == 1;
        end
        m_ready = 1'b1;
        repeat (10) @(negedge rd_clk);
        chk("empty_m_valid", 32'(m_valid), 0);
        chk("empty_cnt", 32'(word_cnt), 37);

        // flush with a word in flight
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) fq.push_back(DW'(8'hA0 + i));
        n = 0;
        while (occupancy != 2 && n < 20) begin
            @(negedge rd_clk);
            n++;
        end
        chk("fl_fill", 32'(occupancy), 2);
        m_ready = 1'b1;
        #3 chk("fl_pop_issued", 32'(fifo_rd_en), 1);
        @(negedge rd_clk);
        m_ready = 1'b0;
        flush = 1'b1;
        @(negedge rd_clk);
        flush = 1'b0;
        chk("fl_m_valid", 32'(m_valid), 0);
        m_ready = 1'b1;
        n = 0;
        while (!m_valid && n < 10) begin
            @(negedge rd_clk);
            n++;
        end
        chk("fl_next_word", 32'(m_data), 32'hA3);
        repeat (10) @(negedge rd_clk);

        // randomized traffic with occasional flushes
        repeat (400) begin
            @(negedge rd_clk);
            m_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 39) == 0;
            if ($urandom_range(0, 2) == 0) begin
                fq.push_back(DW'($urandom));
                if ($urandom_range(0, 1) == 1) fq.push_back(DW'($urandom));
            end
        end
        @(negedge rd_clk);
        flush = 1'b0;
        m_ready = 1'b1;
        repeat (200) @(negedge rd_clk);
        chk("rand_drained", 32'(m_valid), 0);

        // reset in the middle of streaming
        for (int i = 0; i < 8; i++) fq.push_back(DW'(8'hC0 + i));
        repeat (3) @(negedge rd_clk);
        #5 rd_rst_n = 1'b0;
        #1;
        chk("mid_rst_rd_en", 32'(fifo_rd_en), 0);
        chk("mid_rst_m_valid", 32'(m_valid), 0);
        chk("mid_rst_occupancy", 32'(occupancy), 0);
        chk("mid_rst_word_cnt", 32'(word_cnt), 0);
        chk("mid_rst_m_data", 32'(m_data), 0);
        repeat (2) @(negedge rd_clk);
        rd_rst_n = 1'b1;
        repeat (20) @(negedge rd_clk);
        chk("post_rst_drained", 32'(m_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
